// File: rtl/apb_pkg.sv
// Shared APB definitions: slave FSM states, bus widths and phase decode helpers.
package apb_pkg;

  typedef enum logic [0:0] {S_IDLE, S_ACCESS} apb_slv_state_t;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;
  localparam int APB_WAIT_W = 4;

  function automatic logic is_setup(input logic psel, input logic penable);
    return psel & ~penable;
  endfunction

  function automatic logic is_access(input logic psel, input logic penable);
    return psel & penable;
  endfunction

endpackage

// File: rtl/apb_regfile_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, combinational read port,
// every entry cleared by synchronous reset.
module apb_regfile_mem
  import apb_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = APB_DATA_W,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_reg [DEPTH];

  // Per-entry registers so the whole array can be cleared in one reset cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [AW-1:0] IDX = AW'(gi);
      always_ff @(posedge clk) begin
        if (srst) begin
          mem_reg[gi] <= '0;
        end else if (we && (waddr == IDX)) begin
          mem_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer serving a byte register file with a read-only ID at address 0,
// programmable wait states and pslverr on out-of-range or ID writes.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(8'hA5)
) (
  input  logic              clk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int MEM_AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [APB_WAIT_W-1:0] WAIT_INIT =
      (WAIT_STATES == 0) ? '0 : APB_WAIT_W'(WAIT_STATES - 1);

  apb_slv_state_t          state_reg, state_next;
  logic [APB_WAIT_W-1:0]   cnt_reg, cnt_next;
  logic [ADDR_W-1:0]       addr_reg, addr_next;
  logic                    write_reg, write_next;
  logic [DATA_W-1:0]       wdata_reg, wdata_next;
  logic [DATA_W-1:0]       prdata_reg, prdata_next;
  logic                    pready_reg, pready_next;
  logic                    pslverr_reg, pslverr_next;

  logic [ADDR_W-1:0]       dec_addr;
  logic                    dec_write;
  logic                    dec_err;
  logic [DATA_W-1:0]       resp_data;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    mem_we;

  // In IDLE the response may be loaded at the SETUP edge itself (zero wait
  // states), before the address is captured, so decode the live bus there.
  assign dec_addr  = (state_reg == S_IDLE) ? paddr  : addr_reg;
  assign dec_write = (state_reg == S_IDLE) ? pwrite : write_reg;
  assign dec_err   = ({1'b0, dec_addr} >= DEPTH_LIM) || (dec_write && (dec_addr == '0));
  assign resp_data = (dec_write || dec_err) ? '0 :
                     (dec_addr == '0)       ? ID_VALUE : mem_rdata;

  assign mem_we = (state_reg == S_ACCESS) && pready_reg && is_access(psel, penable)
                  && write_reg && !dec_err;

  apb_regfile_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .srst  (preset),
    .we    (mem_we),
    .waddr (addr_reg[MEM_AW-1:0]),
    .wdata (wdata_reg),
    .raddr (dec_addr[MEM_AW-1:0]),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    addr_next    = addr_reg;
    write_next   = write_reg;
    wdata_next   = wdata_reg;
    prdata_next  = '0;
    pready_next  = 1'b0;
    pslverr_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (is_setup(psel, penable)) begin
          addr_next  = paddr;
          write_next = pwrite;
          wdata_next = pwdata;
          state_next = S_ACCESS;
          if (WAIT_STATES == 0) begin
            cnt_next     = '0;
            pready_next  = 1'b1;
            prdata_next  = resp_data;
            pslverr_next = dec_err;
          end else begin
            cnt_next = WAIT_INIT;
          end
        end
      end
      S_ACCESS: begin
        // Abort (psel low or a fresh SETUP) and normal completion both end here.
        if (!is_access(psel, penable) || pready_reg) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          pready_next  = 1'b1;
          prdata_next  = resp_data;
          pslverr_next = dec_err;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (preset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      write_reg   <= 1'b0;
      wdata_reg   <= '0;
      prdata_reg  <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      addr_reg    <= addr_next;
      write_reg   <= write_next;
      wdata_reg   <= wdata_next;
      prdata_reg  <= prdata_next;
      pready_reg  <= pready_next;
      pslverr_reg <= pslverr_next;
    end
  end

  assign prdata  = prdata_reg;
  assign pready  = pready_reg;
  assign pslverr = pslverr_reg;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench: four slaves with WAIT_STATES 0..3 share one APB bus; the driver queues
// expected responses and a negedge monitor compares them whenever a slave raises pready.
module tb_apb_slave_regfile;

  logic       clk = 1'b0;
  logic       preset;
  logic [3:0] psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata [4];
  logic [3:0] pready;
  logic [3:0] pslverr;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      apb_slave_regfile #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .DEPTH       (64),
        .WAIT_STATES (gi),
        .ID_VALUE    (8'hA5)
      ) u_dut (
        .clk     (clk),
        .preset  (preset),
        .psel    (psel[gi]),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata[gi]),
        .pready  (pready[gi]),
        .pslverr (pslverr[gi])
      );
    end
  endgenerate

  typedef struct {
    int         inst;
    logic [7:0] rdata;
    logic       err;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (pready[i] === 1'b1) begin
        if (sb_q.size() == 0) begin
          check($sformatf("unexpected_pready inst%0d", i), 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check({e.tag, " inst"}, i, e.inst);
          check({e.tag, " prdata"}, {24'd0, prdata[i]}, {24'd0, e.rdata});
          check({e.tag, " pslverr"}, {31'd0, pslverr[i]}, {31'd0, e.err});
          $display("txn %s inst=%0d prdata=%02h pslverr=%0b", e.tag, i, prdata[i], pslverr[i]);
        end
      end
    end
  end

  // Called 1ns after a rising edge; that cycle becomes SETUP (T0).
  task automatic apb_xfer(input int inst, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rd,
                          input logic exp_err, input string tag);
    exp_t e;
    int   cyc;
    e.inst = inst; e.rdata = exp_rd; e.err = exp_err; e.tag = tag;
    sb_q.push_back(e);
    psel = '0; psel[inst] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    // Bus changes during ACCESS must be ignored by the slave.
    pwrite = ~wr; paddr = ~addr; pwdata = ~wdata;
    cyc = 1;
    while (pready[inst] !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, inst + 1);
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
  endtask

  task automatic apb_abort(input int inst, input logic [7:0] addr, input logic [7:0] wdata,
                           input logic resetup, input string tag);
    psel = '0; psel[inst] = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    if (!resetup) begin
      penable = 1'b1;
      @(posedge clk); #1;
      psel = '0; penable = 1'b0;
    end
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("txn %s inst=%0d abort issued", tag, inst);
  endtask

  initial begin
    preset = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset pready inst%0d", i), {31'd0, pready[i]}, 32'd0);
      check($sformatf("reset pslverr inst%0d", i), {31'd0, pslverr[i]}, 32'd0);
      check($sformatf("reset prdata inst%0d", i), {24'd0, prdata[i]}, 32'd0);
    end
    preset = 1'b0;
    @(posedge clk); #1;

    apb_xfer(0, 1'b0, 8'd0,  8'h00, 8'hA5, 1'b0, "t1_rd_id");
    apb_xfer(0, 1'b1, 8'd5,  8'h3C, 8'h00, 1'b0, "t2_wr5");
    apb_xfer(0, 1'b0, 8'd5,  8'h00, 8'h3C, 1'b0, "t2_rd5");

    apb_xfer(3, 1'b1, 8'd5,  8'h3C, 8'h00, 1'b0, "t3_wr5");
    apb_xfer(3, 1'b0, 8'd5,  8'h00, 8'h3C, 1'b0, "t3_rd5");
    apb_xfer(1, 1'b0, 8'd5,  8'h00, 8'h00, 1'b0, "t3_rd5_other");

    apb_xfer(0, 1'b1, 8'd0,  8'hFF, 8'h00, 1'b1, "t4_wr_id");
    apb_xfer(0, 1'b0, 8'd64, 8'h00, 8'h00, 1'b1, "t4_rd64");
    apb_xfer(0, 1'b0, 8'd0,  8'h00, 8'hA5, 1'b0, "t4_rd_id");
    apb_xfer(0, 1'b1, 8'd63, 8'h5A, 8'h00, 1'b0, "t4_wr63");
    apb_xfer(0, 1'b0, 8'd63, 8'h00, 8'h5A, 1'b0, "t4_rd63");
    apb_xfer(0, 1'b1, 8'd69, 8'h11, 8'h00, 1'b1, "t4_wr69");
    apb_xfer(0, 1'b0, 8'd5,  8'h00, 8'h3C, 1'b0, "t4_rd5_intact");

    apb_abort(2, 8'd9, 8'h77, 1'b0, "t5_drop_psel");
    apb_abort(2, 8'd9, 8'h77, 1'b1, "t5_resetup");
    apb_xfer(2, 1'b0, 8'd9,  8'h00, 8'h00, 1'b0, "t5_rd9");
    apb_xfer(2, 1'b1, 8'd9,  8'h42, 8'h00, 1'b0, "t5_wr9");
    apb_xfer(2, 1'b0, 8'd9,  8'h00, 8'h42, 1'b0, "t5_rd9_again");

    apb_xfer(1, 1'b1, 8'd7,  8'h55, 8'h00, 1'b0, "t6_wr7");
    apb_xfer(1, 1'b0, 8'd7,  8'h00, 8'h55, 1'b0, "t6_rd7_pre");
    psel = '0; psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd7; pwdata = 8'h77;
    @(posedge clk); #1;
    penable = 1'b1; preset = 1'b1;
    @(posedge clk); #1;
    check("t6_midreset pready", {31'd0, pready[1]}, 32'd0);
    check("t6_midreset pslverr", {31'd0, pslverr[1]}, 32'd0);
    check("t6_midreset prdata", {24'd0, prdata[1]}, 32'd0);
    $display("txn t6_midreset inst=1 reset during write");
    preset = 1'b0; psel = '0; penable = 1'b0;
    @(posedge clk); #1;
    apb_xfer(1, 1'b0, 8'd7,  8'h00, 8'h00, 1'b0, "t6_rd7");
    apb_xfer(0, 1'b0, 8'd5,  8'h00, 8'h00, 1'b0, "t6_rd5_cleared");

    psel = 4'b0001; penable = 1'b1; paddr = 8'd0; pwrite = 1'b0;
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("txn t6_penable_pulse inst=0 no setup");
    apb_xfer(0, 1'b0, 8'd0,  8'h00, 8'hA5, 1'b0, "t6_rd_id");

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
